matrix_operand_bank: RTL and testbench
======================================

Name: matrix_operand_bank

Overview:
Responder/storage end of the matrix multiplier's index-and-strobe interface. Holds operand matrices A and B, loaded by a host. Serves a_in/b_in combinationally from the a_i/a_j/b_i/b_j indices the multiplier drives. Accepts z_out/z_i/z_j results under z_stb/z_ack, stores them in result matrix Z, sequences the multiplier's start/done, and offers host readback of Z.

Parameters:
m, 4, matrix dimension (m x m); valid range 2..16.
IW, 5, index port width; matches the multiplier's 5-bit index ports.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous reset, active-high.
ld_valid  in  1  host writes one operand element this cycle.
ld_sel  in  1  0 = A, 1 = B.
ld_i  in  IW  row of loaded element.
ld_j  in  IW  column of loaded element.
ld_data  in  32  element value (IEEE-754 single, opaque here).
go  in  1  host request to run a multiply.
busy  out  1  multiply in progress.
result_valid  out  1  Z complete and stable; held until next go.
rd_i  in  IW  readback row.
rd_j  in  IW  readback column.
rd_data  out  32  Z[rd_i][rd_j], registered, 1-cycle latency.
z_wr_count  out  16  Z captures since last go.
mul_start  out  1  start pulse to multiplier.
mul_done  in  1  multiplier done pulse.
a_i  in  IW  A row index from multiplier.
a_j  in  IW  A column index.
b_i  in  IW  B row index.
b_j  in  IW  B column index.
a_in  out  32  A[a_i][a_j], combinational.
b_in  out  32  B[b_i][b_j], combinational.
z_out  in  32  result value.
z_i  in  IW  result row.
z_j  in  IW  result column.
z_stb  in  1  result valid.
z_ack  out  1  result accepted, one-cycle pulse.

Behaviour:
- Reset: all A/B/Z words = 0; busy = 0, result_valid = 0, mul_start = 0, z_ack = 0, rd_data = 0, z_wr_count = 0, both FSMs idle. Reset mid-run aborts the run immediately, with no completion.
- Control FSM states: C_IDLE, C_START, C_RUN, C_DONE.
  - C_IDLE: go=1 moves to C_START. That same edge clears Z, clears z_wr_count, drops result_valid and sets busy.
  - C_START: mul_start=1 for exactly one cycle, then C_RUN.
  - C_RUN: on mul_done=1, go to C_DONE.
  - C_DONE: busy=0, result_valid=1, then C_IDLE.
- go while busy: ignored.
- Loads: on ld_valid=1 while busy=0, the selected matrix element is written at the next edge. ld_valid while busy=1 is dropped, and A/B stay stable for the whole run.
- Z handshake FSM states: Z_IDLE, Z_ACK, Z_DROP. It runs in any control state.
  - Z_IDLE, z_stb=1: capture Z[z_i][z_j] <= z_out, z_wr_count += 1 (saturates at 0xFFFF), go to Z_ACK.
  - Z_ACK: z_ack=1 for one cycle, then Z_DROP.
  - Z_DROP: wait for z_stb=0, then Z_IDLE. This prevents double capture while the initiator's strobe falls.
- Latency: z_stb high at edge t gives capture at t+1 and z_ack high during cycle t+1..t+2. Minimum 3 cycles per transfer.
- The same index may be written repeatedly (one partial sum per k); last write wins. Expected z_wr_count after a full m=4 run is m^3 = 64.
- A z_stb arriving in C_IDLE is still captured and acked; z_wr_count still increments.
- mul_done arriving while a Z transfer is in Z_ACK/Z_DROP: the control FSM still completes. The capture has already occurred, so Z is final.
- Readback: rd_data <= Z[rd_i][rd_j] every cycle. Readback is valid at any time, but contents are meaningful only when result_valid=1.
- Indices >= m without the feature: a_in/b_in = 0, loads and z writes are discarded, and the z handshake still completes.

Optional Feature:
IDX_CHECK_EN: adds output idx_err (1 bit, reset 0, sticky until the next go or rst).
- It is set on the edge following any out-of-range index: a_i/a_j/b_i/b_j while C_RUN, z_i/z_j on capture, or ld_i/ld_j on an accepted load.
- Without the macro, the port is absent and out-of-range accesses are silently handled as above.

Test Plan:
- Load A = identity, B[i][j] = 0x3F800000*(i+1) pattern, pulse go -> mul_start high exactly 1 cycle at go+1, busy=1. Model drives mul_done -> result_valid=1 two cycles later, busy=0.
- Single z_stb with z_i=2, z_j=1, z_out=0x40400000, held until z_ack -> z_ack high 1 cycle at stb+1; rd_i=2, rd_j=1 gives rd_data=0x40400000 one cycle after; z_wr_count=1.
- z_stb held high 5 cycles after ack -> exactly one capture, z_wr_count unchanged, no second z_ack until stb drops and rises again.
- Full m=4 run with behavioural initiator writing 64 partial sums -> z_wr_count=64, Z equals last value per index. ld_valid pulses during the run leave A/B unchanged.
- Assert rst during C_RUN with z transfer in Z_ACK -> all outputs 0 immediately; a subsequent go runs cleanly.
- With IDX_CHECK_EN: z_i=7 capture attempt -> z_ack still pulses, Z unchanged, idx_err=1 until next go.

Source files
------------

// File: rtl/matrix_operand_bank_if.sv
// Index-and-strobe link between the matrix multiplier (master) and the operand bank (slave).
// Carries operand fetch indices/data, result write-back handshake and start/done sequencing.
interface matrix_operand_bank_if #(
    parameter int IW = 5
);
    logic          mul_start;
    logic          mul_done;
    logic [IW-1:0] a_i;
    logic [IW-1:0] a_j;
    logic [IW-1:0] b_i;
    logic [IW-1:0] b_j;
    logic [31:0]   a_in;
    logic [31:0]   b_in;
    logic [31:0]   z_out;
    logic [IW-1:0] z_i;
    logic [IW-1:0] z_j;
    logic          z_stb;
    logic          z_ack;

    modport master (
        output mul_done, a_i, a_j, b_i, b_j, z_out, z_i, z_j, z_stb,
        input  mul_start, a_in, b_in, z_ack
    );

    modport slave (
        input  mul_done, a_i, a_j, b_i, b_j, z_out, z_i, z_j, z_stb,
        output mul_start, a_in, b_in, z_ack
    );
endinterface

// File: rtl/matrix_operand_bank.sv
// Operand/result storage for the matrix multiplier: host-loaded A/B, captured Z, run sequencing.
// Optional IDX_CHECK_EN adds a sticky idx_err output flagging out-of-range indices.
//
// Control FSM
//   state   | meaning
//   C_IDLE  | waiting for go; host loads and readback allowed
//   C_START | one-cycle mul_start pulse
//   C_RUN   | multiplier running, waiting for mul_done
//   C_DONE  | publish result_valid, release busy
// Z handshake FSM
//   state   | meaning
//   Z_IDLE  | waiting for z_stb; capture on strobe
//   Z_ACK   | one-cycle z_ack pulse
//   Z_DROP  | waiting for initiator to release z_stb
module matrix_operand_bank #(
    parameter int m  = 4,
    parameter int IW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_valid,
    input  logic          ld_sel,
    input  logic [IW-1:0] ld_i,
    input  logic [IW-1:0] ld_j,
    input  logic [31:0]   ld_data,
    input  logic          go,
    output logic          busy,
    output logic          result_valid,
    input  logic [IW-1:0] rd_i,
    input  logic [IW-1:0] rd_j,
    output logic [31:0]   rd_data,
    output logic [15:0]   z_wr_count,
`ifdef IDX_CHECK_EN
    output logic          idx_err,
`endif
    matrix_operand_bank_if.slave mul
);
    localparam int AW = (m > 1) ? $clog2(m) : 1;

    typedef enum logic [1:0] {C_IDLE, C_START, C_RUN, C_DONE} ctl_t;
    typedef enum logic [1:0] {Z_IDLE, Z_ACK, Z_DROP} zst_t;

    ctl_t ctl, ctl_nxt;
    zst_t z_st, z_nxt;
    logic go_acc, z_cap, ld_acc;
    logic ld_ok, z_ok, rd_ok, a_ok, b_ok;

    logic [31:0] a_mem [m][m];
    logic [31:0] b_mem [m][m];
    logic [31:0] z_mem [m][m];

    function automatic logic in_rng(input logic [IW-1:0] i, input logic [IW-1:0] j);
        return (i < IW'(m)) && (j < IW'(m));
    endfunction

    assign ld_ok  = in_rng(ld_i, ld_j);
    assign z_ok   = in_rng(mul.z_i, mul.z_j);
    assign rd_ok  = in_rng(rd_i, rd_j);
    assign a_ok   = in_rng(mul.a_i, mul.a_j);
    assign b_ok   = in_rng(mul.b_i, mul.b_j);
    assign ld_acc = ld_valid && !busy;

    always_comb begin
        ctl_nxt = ctl;
        go_acc  = 1'b0;
        unique case (ctl)
            C_IDLE: begin
                if (go) begin
                    ctl_nxt = C_START;
                    go_acc  = 1'b1;
                end
            end
            C_START: ctl_nxt = C_RUN;
            C_RUN:   if (mul.mul_done) ctl_nxt = C_DONE;
            C_DONE:  ctl_nxt = C_IDLE;
            default: ctl_nxt = C_IDLE;
        endcase
    end

    always_comb begin
        z_nxt = z_st;
        z_cap = 1'b0;
        unique case (z_st)
            Z_IDLE: begin
                if (mul.z_stb) begin
                    z_cap = 1'b1;
                    z_nxt = Z_ACK;
                end
            end
            Z_ACK:   z_nxt = Z_DROP;
            Z_DROP:  if (!mul.z_stb) z_nxt = Z_IDLE;
            default: z_nxt = Z_IDLE;
        endcase
    end

    assign mul.mul_start = (ctl == C_START);
    assign mul.z_ack     = (z_st == Z_ACK);

    always_comb begin
        mul.a_in = '0;
        mul.b_in = '0;
        if (a_ok) mul.a_in = a_mem[mul.a_i[AW-1:0]][mul.a_j[AW-1:0]];
        if (b_ok) mul.b_in = b_mem[mul.b_i[AW-1:0]][mul.b_j[AW-1:0]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctl          <= C_IDLE;
            z_st         <= Z_IDLE;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            z_wr_count   <= '0;
            rd_data      <= '0;
        end else begin
            ctl  <= ctl_nxt;
            z_st <= z_nxt;
            if (go_acc) begin
                busy         <= 1'b1;
                result_valid <= 1'b0;
            end else if (ctl == C_DONE) begin
                busy         <= 1'b0;
                result_valid <= 1'b1;
            end
            // a capture coinciding with go belongs to the new run
            if (go_acc)
                z_wr_count <= z_cap ? 16'd1 : 16'd0;
            else if (z_cap && (z_wr_count != 16'hFFFF))
                z_wr_count <= z_wr_count + 16'd1;
            rd_data <= rd_ok ? z_mem[rd_i[AW-1:0]][rd_j[AW-1:0]] : 32'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < m; i++) begin
                for (int j = 0; j < m; j++) begin
                    a_mem[i][j] <= '0;
                    b_mem[i][j] <= '0;
                    z_mem[i][j] <= '0;
                end
            end
        end else begin
            if (ld_acc && ld_ok) begin
                if (ld_sel) b_mem[ld_i[AW-1:0]][ld_j[AW-1:0]] <= ld_data;
                else        a_mem[ld_i[AW-1:0]][ld_j[AW-1:0]] <= ld_data;
            end
            if (go_acc) begin
                for (int i = 0; i < m; i++)
                    for (int j = 0; j < m; j++)
                        z_mem[i][j] <= '0;
            end
            if (z_cap && z_ok) z_mem[mul.z_i[AW-1:0]][mul.z_j[AW-1:0]] <= mul.z_out;
        end
    end

`ifdef IDX_CHECK_EN
    logic idx_set;
    assign idx_set = ((ctl == C_RUN) && (!a_ok || !b_ok)) ||
                     (z_cap && !z_ok) ||
                     (ld_acc && !ld_ok);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          idx_err <= 1'b0;
        else if (go_acc)  idx_err <= 1'b0;
        else if (idx_set) idx_err <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_matrix_operand_bank.sv
// Directed self-checking bench for matrix_operand_bank with a readback scoreboard.
module tb_matrix_operand_bank;
    localparam int M  = 4;
    localparam int IW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          ld_valid, ld_sel, go;
    logic [IW-1:0] ld_i, ld_j, rd_i, rd_j;
    logic [31:0]   ld_data, rd_data;
    logic          busy, result_valid;
    logic [15:0]   z_wr_count;
`ifdef IDX_CHECK_EN
    logic          idx_err;
`endif

    matrix_operand_bank_if #(.IW(IW)) mif ();

    matrix_operand_bank #(.m(M), .IW(IW)) dut (
        .clk          (clk),
        .rst          (rst),
        .ld_valid     (ld_valid),
        .ld_sel       (ld_sel),
        .ld_i         (ld_i),
        .ld_j         (ld_j),
        .ld_data      (ld_data),
        .go           (go),
        .busy         (busy),
        .result_valid (result_valid),
        .rd_i         (rd_i),
        .rd_j         (rd_j),
        .rd_data      (rd_data),
        .z_wr_count   (z_wr_count),
`ifdef IDX_CHECK_EN
        .idx_err      (idx_err),
`endif
        .mul          (mif)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] am [M][M];
    logic [31:0] bm [M][M];
    logic [31:0] zm [M][M];
    logic [31:0] sb [$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ld(input logic sel, input int i, input int j, input logic [31:0] d);
        ld_valid = 1'b1;
        ld_sel   = sel;
        ld_i     = IW'(i);
        ld_j     = IW'(j);
        ld_data  = d;
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input int i, input int j, input logic [31:0] exp);
        logic [31:0] e;
        rd_i = IW'(i);
        rd_j = IW'(j);
        sb.push_back(exp);
        tick();
        e = sb.pop_front();
        chk(tag, rd_data, e);
    endtask

    // one result transfer; initiator keeps z_stb up for 'hold' cycles after seeing z_ack
    task automatic z_xfer(input int i, input int j, input logic [31:0] v, input int hold);
        int n;
        bit acked;
        mif.z_i   = IW'(i);
        mif.z_j   = IW'(j);
        mif.z_out = v;
        mif.z_stb = 1'b1;
        n = 0;
        acked = 1'b0;
        while (n < 8 && !acked) begin
            tick();
            n++;
            if (mif.z_ack) acked = 1'b1;
        end
        chk("z_ack_latency", 32'(n), 32'd1);
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("z_ack_no_repeat", {31'd0, mif.z_ack}, 32'd0);
        end
        mif.z_stb = 1'b0;
        tick();
        tick();
    endtask

    task automatic start_run();
        go = 1'b1;
        tick();
        go = 1'b0;
        chk("mul_start_pulse", {31'd0, mif.mul_start}, 32'd1);
        chk("busy_after_go", {31'd0, busy}, 32'd1);
        tick();
        chk("mul_start_single", {31'd0, mif.mul_start}, 32'd0);
    endtask

    task automatic finish_run();
        mif.mul_done = 1'b1;
        tick();
        mif.mul_done = 1'b0;
        chk("rv_not_yet", {31'd0, result_valid}, 32'd0);
        tick();
        chk("result_valid", {31'd0, result_valid}, 32'd1);
        chk("busy_released", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [31:0] v;
        rst = 1'b1;
        ld_valid = 1'b0; ld_sel = 1'b0; ld_i = '0; ld_j = '0; ld_data = '0;
        go = 1'b0; rd_i = '0; rd_j = '0;
        mif.mul_done = 1'b0; mif.a_i = '0; mif.a_j = '0; mif.b_i = '0; mif.b_j = '0;
        mif.z_out = '0; mif.z_i = '0; mif.z_j = '0; mif.z_stb = 1'b0;
        for (int i = 0; i < M; i++)
            for (int j = 0; j < M; j++) begin
                am[i][j] = '0; bm[i][j] = '0; zm[i][j] = '0;
            end
        tick();
        tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rv", {31'd0, result_valid}, 32'd0);
        chk("rst_mul_start", {31'd0, mif.mul_start}, 32'd0);
        chk("rst_z_ack", {31'd0, mif.z_ack}, 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_count", {16'd0, z_wr_count}, 32'd0);
        rst = 1'b0;
        tick();

        // A = identity, B[i][j] = 0x3F800000*(i+1)
        for (int i = 0; i < M; i++)
            for (int j = 0; j < M; j++) begin
                am[i][j] = (i == j) ? 32'h3F80_0000 : 32'd0;
                bm[i][j] = 32'h3F80_0000 * 32'(i + 1);
                ld(1'b0, i, j, am[i][j]);
                ld(1'b1, i, j, bm[i][j]);
            end
        ld(1'b0, 4, 0, 32'hFFFF_FFFF);
        for (int i = 0; i < M; i++) begin
            mif.a_i = IW'(i); mif.a_j = IW'(i);
            mif.b_i = IW'(i); mif.b_j = IW'(3 - i);
            #1;
            chk("a_in_diag", mif.a_in, am[i][i]);
            chk("b_in_pat", mif.b_in, bm[i][3 - i]);
        end
        mif.a_i = 5'd5; mif.a_j = 5'd0; mif.b_i = 5'd0; mif.b_j = 5'd4;
        #1;
        chk("a_in_oor", mif.a_in, 32'd0);
        chk("b_in_oor", mif.b_in, 32'd0);
        mif.a_i = 5'd0; mif.a_j = 5'd0; mif.b_i = 5'd0; mif.b_j = 5'd0;

        // capture while idle, then a strobe held long after ack
        z_xfer(2, 1, 32'h4040_0000, 0);
        chk("count_one", {16'd0, z_wr_count}, 32'd1);
        rd_chk("rd_z21", 2, 1, 32'h4040_0000);
        z_xfer(0, 3, 32'h1111_1111, 5);
        chk("count_held", {16'd0, z_wr_count}, 32'd2);
        rd_chk("rd_z03", 0, 3, 32'h1111_1111);

        // full run
        start_run();
        chk("count_cleared", {16'd0, z_wr_count}, 32'd0);
        rd_chk("z_cleared", 2, 1, 32'd0);
`ifdef IDX_CHECK_EN
        chk("idx_err_cleared_by_go", {31'd0, idx_err}, 32'd0);
`endif
        ld(1'b0, 0, 0, 32'hDEAD_BEEF);
        ld(1'b1, 1, 1, 32'hCAFE_F00D);
        for (int i = 0; i < M; i++)
            for (int j = 0; j < M; j++)
                for (int k = 0; k < M; k++) begin
                    mif.a_i = IW'(i); mif.a_j = IW'(k);
                    mif.b_i = IW'(k); mif.b_j = IW'(j);
                    #1;
                    chk("run_a_in", mif.a_in, am[i][k]);
                    chk("run_b_in", mif.b_in, bm[k][j]);
                    v = {8'hA5, 8'(i), 8'(j), 8'(k)};
                    zm[i][j] = v;
                    z_xfer(i, j, v, 0);
                end
        chk("count_full", {16'd0, z_wr_count}, 32'd64);
        z_xfer(7, 1, 32'h0BAD_0BAD, 0);
`ifdef IDX_CHECK_EN
        chk("idx_err_set", {31'd0, idx_err}, 32'd1);
`endif
        finish_run();
        for (int i = 0; i < M; i++)
            for (int j = 0; j < M; j++)
                rd_chk("rd_full", i, j, zm[i][j]);
        mif.a_i = 5'd0; mif.a_j = 5'd0; mif.b_i = 5'd1; mif.b_j = 5'd1;
        #1;
        chk("a_stable", mif.a_in, am[0][0]);
        chk("b_stable", mif.b_in, bm[1][1]);
`ifdef IDX_CHECK_EN
        chk("idx_err_sticky", {31'd0, idx_err}, 32'd1);
`endif

        // reset in C_RUN while a transfer sits in Z_ACK
        mif.a_i = 5'd1; mif.a_j = 5'd1;
        start_run();
`ifdef IDX_CHECK_EN
        chk("idx_err_cleared_go2", {31'd0, idx_err}, 32'd0);
`endif
        mif.z_i = 5'd1; mif.z_j = 5'd1; mif.z_out = 32'h5555_5555; mif.z_stb = 1'b1;
        tick();
        chk("pre_rst_ack", {31'd0, mif.z_ack}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_rv", {31'd0, result_valid}, 32'd0);
        chk("mid_rst_z_ack", {31'd0, mif.z_ack}, 32'd0);
        chk("mid_rst_count", {16'd0, z_wr_count}, 32'd0);
        chk("mid_rst_rd", rd_data, 32'd0);
        chk("mid_rst_a_in", mif.a_in, 32'd0);
        mif.z_stb = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_mul_start", {31'd0, mif.mul_start}, 32'd0);
        ld(1'b0, 1, 1, 32'h4000_0000);
        #1;
        chk("reload_a", mif.a_in, 32'h4000_0000);
        start_run();
        z_xfer(1, 2, 32'h1234_5678, 0);
        chk("count_rerun", {16'd0, z_wr_count}, 32'd1);
        finish_run();
        rd_chk("rd_rerun", 1, 2, 32'h1234_5678);
        rd_chk("rd_rst_cleared", 1, 1, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
